// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - Instruction fetch stage with IF/ID register, skid buffer and flush/stall handling.
// Optional perf counters are enabled with `define FETCH_PERF_COUNTERS_EN.
module fetch_stage #(
    parameter int ADDR_W   = 12,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              is_stall,
    input  logic              is_flush,
    input  logic [ADDR_W-1:0] branch_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [18:0]       imem_rdata,
    output logic [18:0]       IF_inst,
    output logic [ADDR_W-1:0] IF_pc,
    output logic              IF_valid
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [15:0]       flush_count,
    output logic [15:0]       stall_count
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

    localparam logic [18:0] BUBBLE = 19'h00000;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [18:0]       skid_inst;
    logic [ADDR_W-1:0] skid_pc;
    logic              skid_valid;

    assign pc_inc = pc + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= ADDR_W'(RESET_PC);
            state      <= IDLE;
            imem_req   <= 1'b0;
            imem_addr  <= ADDR_W'(RESET_PC);
            IF_inst    <= BUBBLE;
            IF_pc      <= '0;
            IF_valid   <= 1'b0;
            skid_inst  <= BUBBLE;
            skid_pc    <= '0;
            skid_valid <= 1'b0;
        end else if (is_flush) begin
            IF_inst    <= BUBBLE;
            IF_valid   <= 1'b0;
            skid_valid <= 1'b0;
            pc         <= branch_pc;
            imem_req   <= 1'b1;
            // An unanswered request must keep its address until the memory answers it.
            if ((state == REQ || state == DISCARD) && !imem_ack) begin
                state <= DISCARD;
            end else begin
                state     <= REQ;
                imem_addr <= branch_pc;
            end
        end else begin
            case (state)
                IDLE: begin
                    state     <= REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end
                REQ: begin
                    if (imem_ack) begin
                        pc        <= pc_inc;
                        imem_addr <= pc_inc;
                        if (is_stall) begin
                            skid_inst  <= imem_rdata;
                            skid_pc    <= pc;
                            skid_valid <= 1'b1;
                            imem_req   <= 1'b0;
                            state      <= HOLD;
                        end else begin
                            IF_inst  <= imem_rdata;
                            IF_pc    <= pc;
                            IF_valid <= 1'b1;
                        end
                    end else if (!is_stall) begin
                        IF_inst  <= BUBBLE;
                        IF_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!is_stall) begin
                        IF_inst    <= skid_inst;
                        IF_pc      <= skid_pc;
                        IF_valid   <= skid_valid;
                        skid_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        imem_addr  <= pc;
                        state      <= REQ;
                    end
                end
                default: begin
                    IF_inst  <= BUBBLE;
                    IF_valid <= 1'b0;
                    if (imem_ack) begin
                        imem_addr <= pc;
                        state     <= REQ;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_count <= '0;
            stall_count <= '0;
        end else begin
            if (is_flush && flush_count != 16'hFFFF) begin
                flush_count <= flush_count + 16'd1;
            end
            if (is_stall && !is_flush && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - Scoreboard bench for fetch_stage with a latency-modelled instruction memory.
module tb_fetch_stage;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          is_stall = 1'b0;
    logic          is_flush = 1'b0;
    logic [AW-1:0] branch_pc = '0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [18:0]   imem_rdata = '0;
    logic [18:0]   IF_inst;
    logic [AW-1:0] IF_pc;
    logic          IF_valid;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [15:0]   flush_count;
    logic [15:0]   stall_count;
    logic [15:0]   fc_model = '0;
    logic [15:0]   sc_model = '0;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.ADDR_W(AW), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .is_stall(is_stall), .is_flush(is_flush),
        .branch_pc(branch_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .IF_inst(IF_inst), .IF_pc(IF_pc), .IF_valid(IF_valid)
`ifdef FETCH_PERF_COUNTERS_EN
        , .flush_count(flush_count), .stall_count(stall_count)
`endif
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instruction memory: one request at a time, ack after lat cycles.
    logic [18:0]   mem [0:4095];
    bit            pending = 1'b0;
    int            cnt = 0;
    logic [AW-1:0] paddr = '0;
    int            lat_fixed = 1;

    always @(negedge clk) begin
        if (rst) begin
            pending    = 1'b0;
            imem_ack   = 1'b0;
            imem_rdata = '0;
        end else begin
            if (imem_ack) begin
                pending    = 1'b0;
                imem_ack   = 1'b0;
                imem_rdata = 19'($urandom);
            end
            if (pending && imem_req) check("addr_stable", 32'(imem_addr), 32'(paddr));
            if (!pending && imem_req) begin
                pending = 1'b1;
                paddr   = imem_addr;
                cnt     = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
            end else if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem[paddr];
                end
            end
        end
    end

    // Reference model: after reset or a flush the accepted stream is target, target+1, ...
    typedef struct {
        logic [AW-1:0] pc;
        logic [18:0]   inst;
    } exp_t;
    exp_t          exp_q[$];
    logic [AW-1:0] exp_tail = '0;
    logic [AW-1:0] seen_q[$];
    int            n_out = 0;
    bit            edge_stall = 1'b0;
    bit            edge_live = 1'b0;
    bit            started = 1'b0;

    task automatic push_one();
        exp_t e;
        e.pc   = exp_tail;
        e.inst = mem[exp_tail];
        exp_q.push_back(e);
        exp_tail = exp_tail + AW'(1);
    endtask

    task automatic restart(input logic [AW-1:0] p);
        exp_q.delete();
        exp_tail = p;
        for (int i = 0; i < 8; i++) push_one();
    endtask

    always @(posedge clk) begin
        started    = 1'b1;
        edge_stall = is_stall;
        edge_live  = !rst;
        if (rst) restart(AW'(0));
        else if (is_flush) restart(branch_pc);
`ifdef FETCH_PERF_COUNTERS_EN
        if (rst) begin
            fc_model = '0;
            sc_model = '0;
        end else begin
            if (is_flush && fc_model != 16'hFFFF) fc_model++;
            if (is_stall && !is_flush && sc_model != 16'hFFFF) sc_model++;
        end
`endif
    end

    always @(negedge clk) begin
        if (started) begin
            if (!edge_live) begin
                check("rst_valid", 32'(IF_valid), 32'(0));
                check("rst_inst", 32'(IF_inst), 32'(0));
                check("rst_pc", 32'(IF_pc), 32'(0));
                check("rst_req", 32'(imem_req), 32'(0));
            end else if (!IF_valid) begin
                check("bubble_inst", 32'(IF_inst), 32'(0));
            end else if (!edge_stall) begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_pc", 32'(IF_pc), 32'(e.pc));
                check("out_inst", 32'(IF_inst), 32'(e.inst));
                seen_q.push_back(IF_pc);
                n_out++;
                while (exp_q.size() < 4) push_one();
            end
`ifdef FETCH_PERF_COUNTERS_EN
            check("flush_count", 32'(flush_count), 32'(fc_model));
            check("stall_count", 32'(stall_count), 32'(sc_model));
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic flush_to(input logic [AW-1:0] p, input logic with_stall);
        is_flush  = 1'b1;
        is_stall  = with_stall;
        branch_pc = p;
        tick();
        is_flush = 1'b0;
        is_stall = 1'b0;
    endtask

    task automatic wait_seen(input int n, input string name);
        int i;
        i = 0;
        while (seen_q.size() < n && i < 100) begin
            tick();
            i++;
        end
        check(name, 32'(seen_q.size() >= n), 32'(1));
    endtask

    initial begin
        logic [AW-1:0] old_addr;
        int            i;
        for (int k = 0; k < 4096; k++) mem[k] = 19'($urandom);
        mem[5] = 19'h2A5C3;

        repeat (3) tick();
        rst = 1'b0;

        // Stall while pc 0x005 is acknowledged.
        i = 0;
        while (!(imem_req && imem_addr == 12'h005 && pending && !imem_ack) && i < 100) begin
            tick();
            i++;
        end
        check("reach_pc5", 32'(imem_addr), 32'h005);
        if (seen_q.size() >= 3) begin
            check("first_pc0", 32'(seen_q[0]), 32'h000);
            check("first_pc1", 32'(seen_q[1]), 32'h001);
            check("first_pc2", 32'(seen_q[2]), 32'h002);
        end else begin
            check("first_three_seen", 32'(seen_q.size()), 32'(3));
        end
        is_stall = 1'b1;
        tick();
        tick();
        check("hold_req", 32'(imem_req), 32'(0));
        check("hold_if_pc", 32'(IF_pc), 32'h004);
        check("hold_if_valid", 32'(IF_valid), 32'(1));
        tick();
        is_stall = 1'b0;
        tick();
        check("rel_inst", 32'(IF_inst), 32'h2A5C3);
        check("rel_pc", 32'(IF_pc), 32'h005);
        check("rel_req", 32'(imem_req), 32'(1));
        check("rel_addr", 32'(imem_addr), 32'h006);

        // Flush while a 3-cycle request is pending.
        lat_fixed = 3;
        i = 0;
        while (!(imem_req && pending && !imem_ack && cnt >= 2) && i < 100) begin
            tick();
            i++;
        end
        check("pending_found", 32'(pending && cnt >= 2), 32'(1));
        old_addr = imem_addr;
        seen_q.delete();
        flush_to(12'h040, 1'b0);
        check("flush_bubble_valid", 32'(IF_valid), 32'(0));
        check("flush_bubble_inst", 32'(IF_inst), 32'(0));
        check("discard_addr", 32'(imem_addr), 32'(old_addr));
        wait_seen(1, "flush_seen");
        if (seen_q.size() >= 1) check("flush_first_pc", 32'(seen_q[0]), 32'h040);

        // Flush and stall together.
        lat_fixed = 1;
        repeat (4) tick();
        seen_q.delete();
        flush_to(12'h100, 1'b1);
        check("fs_bubble", 32'(IF_valid), 32'(0));
        i = 0;
        while (!(imem_req && imem_addr == 12'h100) && i < 20) begin
            tick();
            i++;
        end
        check("fs_addr", 32'(imem_addr), 32'h100);
        wait_seen(1, "fs_seen");
        if (seen_q.size() >= 1) check("fs_first_pc", 32'(seen_q[0]), 32'h100);

        // Address wrap.
        repeat (3) tick();
        seen_q.delete();
        flush_to(12'hFFE, 1'b0);
        wait_seen(3, "wrap_seen");
        if (seen_q.size() >= 3) begin
            check("wrap0", 32'(seen_q[0]), 32'hFFE);
            check("wrap1", 32'(seen_q[1]), 32'hFFF);
            check("wrap2", 32'(seen_q[2]), 32'h000);
        end

        // Randomized traffic.
        lat_fixed = 0;
        n_out = 0;
        for (int c = 0; c < 3000; c++) begin
            is_stall  = ($urandom_range(0, 3) == 0);
            is_flush  = ($urandom_range(0, 24) == 0);
            branch_pc = AW'($urandom);
            tick();
        end
        is_stall = 1'b0;
        is_flush = 1'b0;
        repeat (20) tick();
        check("progress", 32'(n_out > 100), 32'(1));

        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage plus IF/ID pipeline register for the 19-bit pipeline.
- Owns the PC and drives the instruction memory request/acknowledge interface.
- Presents the fetched instruction to decode and to the hazard detector.
- Consumes the hazard detector's is_stall (hold) and is_flush (redirect to the EX branch target and insert a bubble).

Parameters:
ADDR_W, 12, PC and instruction-memory address width in words.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
is_stall  input  1  hold IF/ID register and PC this cycle.
is_flush  input  1  taken branch in EX; discard fetched work, redirect.
branch_pc  input  ADDR_W  redirect target, valid when is_flush=1.
imem_req  output  1  fetch request; address held stable until ack.
imem_addr  output  ADDR_W  word address of requested instruction.
imem_ack  input  1  read data valid this cycle; latency 1 or more cycles after req.
imem_rdata  input  19  instruction word, valid with imem_ack.
IF_inst  output  19  IF/ID instruction; 19'h00000 when bubble.
IF_pc  output  ADDR_W  PC of IF_inst.
IF_valid  output  1  IF_inst is a real instruction.

Behaviour:
- Reset (rst=1 at clock edge):
  - pc<=RESET_PC; state<=IDLE.
  - IF_inst<=0, IF_pc<=0, IF_valid<=0, imem_req<=0; skid buffer emptied.
- Request and output rules:
  - imem_req=1 only in REQ and DISCARD; imem_addr=pc in REQ, =old address in DISCARD.
  - Bubble = IF_inst 19'h00000 (opcode 000), IF_valid=0.
- Priority each cycle: rst > is_flush > is_stall > normal.
- States:
  - IDLE: no request; next cycle -> REQ.
  - REQ: request at pc outstanding.
  - HOLD: one instruction parked in skid buffer during stall; no request.
  - DISCARD: flushed request still outstanding; its data must be dropped.
- REQ, no flush, no stall:
  - ack=1: IF_inst<=imem_rdata, IF_pc<=pc, IF_valid<=1, pc<=pc+1, stay REQ (new address next cycle).
  - ack=0: IF/ID loads bubble; pc unchanged.
- REQ, stall:
  - IF/ID holds its value.
  - ack=1: rdata/pc captured in skid, pc<=pc+1, -> HOLD.
  - ack=0: stay REQ.
- HOLD:
  - stall=1: hold everything.
  - stall=0: IF/ID <= skid contents (valid=1), skid emptied, -> REQ.
- Flush, any state:
  - IF/ID loads bubble; skid emptied; pc<=branch_pc.
  - REQ with ack=0 -> DISCARD.
  - REQ with ack=1 -> rdata dropped, -> REQ at branch_pc.
  - HOLD or IDLE -> REQ.
- DISCARD:
  - ack=1: data dropped, -> REQ (address = pc, i.e. branch target).
  - Second flush while in DISCARD: pc<=new branch_pc, stay DISCARD.
  - Stall in DISCARD: no effect on discard; IF/ID holds bubble.
- Arithmetic: pc+1 wraps modulo 2^ADDR_W (0xFFF -> 0x000 at default); no overflow flag.
- Simultaneous flush+stall: flush wins; the stall is ignored that cycle.
- Reset mid-request: request dropped immediately; any later stale ack is ignored while in IDLE.
- Ordering: at most one outstanding request; an instruction is never duplicated or skipped except by flush.

Optional Feature:
FETCH_PERF_COUNTERS_EN
- Defined:
  - Adds outputs flush_count[15:0] and stall_count[15:0].
  - Each is a saturating counter (stops at 16'hFFFF), cleared by rst.
  - flush_count increments per cycle with is_flush=1.
  - stall_count increments per cycle with is_stall=1 and is_flush=0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, RESET_PC=0, zero-latency-after-req memory (ack one cycle after each req) -> IF_valid=0 and IF_inst=0 during reset; first valid IF_pc=0x000, then 0x001, 0x002 with matching rdata.
- is_stall held 3 cycles while ack arrives with 19'h2A5C3 at pc 0x005 -> IF/ID frozen on the prior instruction, imem_req drops in HOLD; on release IF_inst=0x2A5C3, IF_pc=0x005, next req addr 0x006.
- is_flush, branch_pc=0x040, while memory latency is 3 and ack is pending -> bubble; the ack data for the old address is dropped; next imem_addr=0x040, and IF_pc=0x040 is the first valid output.
- is_flush and is_stall asserted in the same cycle, branch_pc=0x100 -> flush behaviour only; next request at 0x100.
- Straight-line fetch from pc 0xFFE -> IF_pc sequence 0xFFE, 0xFFF, 0x000.
- FETCH_PERF_COUNTERS_EN defined: 2 flushes and 5 stall-only cycles -> flush_count=2, stall_count=5; after rst both read 0.
